disp_sel_controller: RTL and testbench
======================================

# disp_sel_controller

Sequencing controller for the board's 4-digit seven-segment display path. It steps the 2-bit display-mode select driven into the display selection mux, either by a debounced push-button or by an optional auto-rotate timer. It then time-multiplexes the returned 16-bit `disp_data` onto four common-anode digits. It sits between the board I/O pins and the display mux, in the single-cycle CPU top level.

## Interface
- `DEBOUNCE_CYCLES`, 20'd1_000_000: consecutive stable cycles required before the button level is accepted.
- `SCAN_CYCLES`, 17'd100_000: cycles each digit stays lit.
- `AUTO_CYCLES`, 28'd100_000_000: cycles between automatic mode steps when `auto_en` is high.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `btn`  in  1: raw, asynchronous, bouncing mode-step button (active-high).
- `auto_en`  in  1: enables auto-rotate of the display mode; level-sensitive, sampled every cycle.
- `disp_data`  in  16: data returned by the display mux for the current `dispSel`; may change any cycle.
- `dispSel`  out  2: mode select to the mux. Encoding: 00 PC/NewPC, 01 Rs/RsData, 10 Rt/RtData, 11 ALU/DB.
- `an`  out  4: digit enables, active-low; `an[3]` is the leftmost digit.
- `seg`  out  8: segments, active-low; `seg[7]`=dp, `seg[6:0]`=g..a.

## Operation
- **Button path**
  - 2-flop synchronizer on `btn`.
  - Debounce counter: while the synced level equals the accepted level, the counter holds at 0. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the accepted level takes the synced level and the counter clears.
  - A 0→1 transition of the accepted level produces a one-cycle `step_btn` pulse. Release produces nothing.
- **Auto path**
  - Auto counter runs only while `auto_en`=1. At `AUTO_CYCLES-1` it wraps to 0 and pulses `step_auto`.
  - `auto_en`=0 clears the counter to 0.
  - `step_btn` also clears the auto counter, so the next auto step comes a full `AUTO_CYCLES` after the press.
- **Mode register**
  - On (`step_btn` | `step_auto`), `dispSel` ← `dispSel`+1, mod 4 (11→00 wrap).
  - Simultaneous pulses produce exactly one increment.
- **Scan**
  - Scan counter wraps at `SCAN_CYCLES-1`; on wrap, the 2-bit digit index increments mod 4 (3→0).
  - Digit k shows hex nibble `disp_data[4k+3:4k]`. The upper byte (digits 3,2) is the first item of the pair, the lower byte (digits 1,0) is the second.
  - dp is lit only on digit 2 (byte separator).
  - Hex decode 0–F, standard a–g shapes, with lowercase b and d.
- **Mode-change blanking**
  - On the cycle `dispSel` changes, the scan index and scan counter reset to 0.
  - `an` is forced to 4'b1111 for one full scan slot, so the stale mux output is never displayed.

## Timing
- **Reset (any cycle, including mid-debounce or mid-scan)**
  - `dispSel`=00, `an`=4'b1111, `seg`=8'hFF.
  - All counters, the synchronizer and the accepted level are cleared to 0, and the index is cleared to 0.
  - The blanking slot is not armed by reset.
- **First edge after `reset` deasserts:** `an`=4'b1110, and `seg` is the registered decode of `disp_data[3:0]` sampled at that edge.
- **`an`/`seg` latency:** both are registered; they reflect the index and `disp_data` from the previous cycle (1-cycle latency).
- **Button latency:** a clean press held ≥ `DEBOUNCE_CYCLES`+3 cycles updates `dispSel` exactly `DEBOUNCE_CYCLES`+3 edges after the first high sample (2 sync + count + step register).
  - Glitches shorter than `DEBOUNCE_CYCLES` never step.
  - Holding the button causes no repeat.
- **Auto step:** `dispSel` changes on the edge after the counter wraps.
- **Blank slot:** lasts `SCAN_CYCLES` cycles, starting the edge after the `dispSel` change. Digit 0 then lights.
- **Step during a blank slot:** restarts the blank slot.

## Test plan
- **Reset:** with `DEBOUNCE_CYCLES`=4, `SCAN_CYCLES`=3, `AUTO_CYCLES`=16, hold `reset` 3 cycles with `disp_data`=16'h12AB → `an`=1111 and `seg`=FF during reset.
  - After release, `an` walks 1110, 1101, 1011, 0111 every 3 cycles.
  - `seg` shows 8'h83 (b), 8'h88 (A), 8'h24 (2 with dp), 8'hF9 (1).
- **Debounce:** `btn` pulses of 1, 2 and 3 cycles → `dispSel` stays 00.
  - A 10-cycle press → `dispSel`=01 exactly 7 edges after `btn` rises, then one blank slot (`an`=1111 for 3 cycles).
- **Wrap:** four clean presses → `dispSel` goes 01, 10, 11, 00.
- **Auto:** `auto_en`=1 → `dispSel` increments every 16 cycles.
  - A press landing on the same cycle as an auto wrap → a single increment, and the next auto step comes 16 cycles later.
- **Reset mid-operation:** assert `reset` while `dispSel`=10, mid-debounce and mid-scan → all outputs return to reset values on the next edge, and a still-held `btn` requires a full fresh debounce.
- **Data tracking:** change `disp_data` every cycle → each `seg` value equals the decode of the nibble selected by the previous-cycle index.

Source files
------------

// File: rtl/disp_sel_controller.sv
// Display-mode sequencer and 4-digit seven-segment scanner.
// Steps dispSel from a debounced button or an auto-rotate timer, and
// multiplexes the returned 16-bit disp_data onto four active-low digits.
module disp_sel_controller #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [16:0] SCAN_CYCLES     = 17'd100_000,
    parameter logic [27:0] AUTO_CYCLES     = 28'd100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        auto_en,
    input  logic [15:0] disp_data,
    output logic [1:0]  dispSel,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    // Active-low g..a shapes for hex digits, lowercase b and d.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic        sync1_q, sync2_q, acc_q, acc_d;
    logic [19:0] db_cnt_q, db_cnt_d;
    logic        step_btn_q, step_btn_d;
    logic [27:0] auto_cnt_q, auto_cnt_d;
    logic        step_auto_q, step_auto_d;
    logic [1:0]  sel_q, sel_d;
    logic [16:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        blank_q, blank_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        step;
    logic [3:0]  nib;

    // Debounce: count while the synced level disagrees with the accepted one;
    // the accept event that raises the level is the button step.
    always_comb begin
        acc_d      = acc_q;
        db_cnt_d   = 20'd0;
        step_btn_d = 1'b0;
        if (sync2_q != acc_q) begin
            if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                acc_d      = sync2_q;
                step_btn_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 20'd1;
            end
        end
    end

    // Auto-rotate timer; a button accept restarts it so the next auto step
    // is a full period after the press.
    always_comb begin
        auto_cnt_d  = 28'd0;
        step_auto_d = 1'b0;
        if (auto_en) begin
            step_auto_d = (auto_cnt_q == AUTO_CYCLES - 28'd1);
            if (!step_btn_d && !step_auto_d)
                auto_cnt_d = auto_cnt_q + 28'd1;
        end
    end

    // Mode register plus scan slot / blanking sequencing.
    always_comb begin
        step       = step_btn_q | step_auto_q;
        sel_d      = step ? sel_q + 2'd1 : sel_q;
        scan_cnt_d = scan_cnt_q + 17'd1;
        idx_d      = idx_q;
        blank_d    = blank_q;
        if (step) begin
            scan_cnt_d = 17'd0;
            idx_d      = 2'd0;
            blank_d    = 1'b1;
        end else if (scan_cnt_q == SCAN_CYCLES - 17'd1) begin
            scan_cnt_d = 17'd0;
            // The blank slot consumes one wrap without advancing the digit.
            if (blank_q) blank_d = 1'b0;
            else         idx_d   = idx_q + 2'd1;
        end
    end

    // Registered digit enable and segment pattern for the current index.
    always_comb begin
        nib   = disp_data[{idx_q, 2'b00} +: 4];
        an_d  = blank_q ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = {(idx_q != 2'd2), hex7(nib)};
    end

    // All state, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            acc_q       <= 1'b0;
            db_cnt_q    <= 20'd0;
            step_btn_q  <= 1'b0;
            auto_cnt_q  <= 28'd0;
            step_auto_q <= 1'b0;
            sel_q       <= 2'd0;
            scan_cnt_q  <= 17'd0;
            idx_q       <= 2'd0;
            blank_q     <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 8'hFF;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            acc_q       <= acc_d;
            db_cnt_q    <= db_cnt_d;
            step_btn_q  <= step_btn_d;
            auto_cnt_q  <= auto_cnt_d;
            step_auto_q <= step_auto_d;
            sel_q       <= sel_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign dispSel = sel_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_disp_sel_controller.sv
// Directed bench for disp_sel_controller with small timing parameters.
module tb_disp_sel_controller;

    logic        clk = 1'b0;
    logic        reset, btn, auto_en;
    logic [15:0] disp_data;
    logic [1:0]  dispSel;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;

    // Active-low g..a patterns, written out by hand.
    logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    disp_sel_controller #(
        .DEBOUNCE_CYCLES(20'd4),
        .SCAN_CYCLES    (17'd3),
        .AUTO_CYCLES    (28'd16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .auto_en  (auto_en),
        .disp_data(disp_data),
        .dispSel  (dispSel),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press_release();
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        repeat (10) tick();
    endtask

    logic [3:0]  exp_an [12] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD,
                                 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7};
    logic [7:0]  exp_seg[12] = '{8'h83, 8'h83, 8'h83, 8'h88, 8'h88, 8'h88,
                                 8'h24, 8'h24, 8'h24, 8'hF9, 8'hF9, 8'hF9};
    logic [15:0] dv     [12] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98,
                                 16'h7654, 16'h3210, 16'h5A5A, 16'hA5A5, 16'h1E2D, 16'hD2E1};

    initial begin
        logic [1:0]  ix;
        logic [15:0] d;
        logic [3:0]  n;

        reset = 1'b1; btn = 1'b0; auto_en = 1'b0; disp_data = 16'h12AB;

        // Reset state held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_an", {12'd0, an}, 16'h000F);
            chk("rst_seg", {8'd0, seg}, 16'h00FF);
            chk("rst_sel", {14'd0, dispSel}, 16'h0000);
        end
        reset = 1'b0;

        // Digit walk after release.
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("walk_an", {12'd0, an}, {12'd0, exp_an[i]});
            chk("walk_seg", {8'd0, seg}, {8'd0, exp_seg[i]});
        end

        // Short glitches never step.
        for (int w = 1; w <= 3; w++) begin
            btn = 1'b1;
            repeat (w) tick();
            btn = 1'b0;
            repeat (10) tick();
            chk("glitch_sel", {14'd0, dispSel}, 16'h0000);
        end

        // Clean press: step lands on the 7th edge, then a 3-cycle blank.
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("press_sel", {14'd0, dispSel}, (i >= 7) ? 16'h0001 : 16'h0000);
            if (i >= 8) chk("blank_an", {12'd0, an}, 16'h000F);
        end
        btn = 1'b0;
        tick();
        chk("after_blank_an", {12'd0, an}, 16'h000E);
        repeat (10) tick();
        chk("release_sel", {14'd0, dispSel}, 16'h0001);

        // Remaining presses wrap through 10, 11, 00.
        press_release(); chk("wrap_sel2", {14'd0, dispSel}, 16'h0002);
        press_release(); chk("wrap_sel3", {14'd0, dispSel}, 16'h0003);
        press_release(); chk("wrap_sel0", {14'd0, dispSel}, 16'h0000);

        // Auto rotate; A_i is the i-th edge after auto_en rises.
        auto_en = 1'b1;
        for (int i = 1; i <= 93; i++) begin
            tick();
            if (i == 42) btn = 1'b1;   // accept lands on A48, same as an auto wrap
            if (i == 52) btn = 1'b0;
            if (i == 70) btn = 1'b1;   // accept at A76, restarts the auto timer
            if (i == 80) btn = 1'b0;
            case (i)
                16: chk("auto_a16", {14'd0, dispSel}, 16'h0000);
                17: chk("auto_a17", {14'd0, dispSel}, 16'h0001);
                32: chk("auto_a32", {14'd0, dispSel}, 16'h0001);
                33: chk("auto_a33", {14'd0, dispSel}, 16'h0002);
                48: chk("coinc_a48", {14'd0, dispSel}, 16'h0002);
                49: chk("coinc_a49", {14'd0, dispSel}, 16'h0003);
                50: chk("coinc_a50", {14'd0, dispSel}, 16'h0003);
                64: chk("coinc_a64", {14'd0, dispSel}, 16'h0003);
                65: chk("coinc_a65", {14'd0, dispSel}, 16'h0000);
                77: chk("btnclr_a77", {14'd0, dispSel}, 16'h0001);
                81: chk("btnclr_a81", {14'd0, dispSel}, 16'h0001);
                92: chk("btnclr_a92", {14'd0, dispSel}, 16'h0001);
                93: chk("btnclr_a93", {14'd0, dispSel}, 16'h0002);
                default: ;
            endcase
        end
        auto_en = 1'b0;

        // Reset mid-debounce and mid-scan with dispSel=10.
        btn = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_an", {12'd0, an}, 16'h000F);
        chk("mid_rst_seg", {8'd0, seg}, 16'h00FF);
        chk("mid_rst_sel", {14'd0, dispSel}, 16'h0000);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) chk("mid_rst_first_an", {12'd0, an}, 16'h000E);
            if (i == 6) chk("mid_rst_f6_sel", {14'd0, dispSel}, 16'h0000);
            if (i == 7) chk("mid_rst_f7_sel", {14'd0, dispSel}, 16'h0001);
        end
        btn = 1'b0;
        repeat (10) tick();

        // Data tracking from a fresh reset; disp_data changes every cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            disp_data = dv[k];
            tick();
            ix = 2'(k / 3);
            d  = dv[k];
            n  = d[{ix, 2'b00} +: 4];
            chk("track_seg", {8'd0, seg}, {8'd0, (ix != 2'd2), hex_lut[n]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
